// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
// ----------------------------------------------------------------------------
// Parametrised single-clock FIFO that buffers tokens between the parser and
// the literal-copy stages of the decompressor. It provides programmable
// full/empty thresholds, an occupancy count and one-cycle overflow/underflow
// pulses.
//
// Build option:
//   FIFO_FWFT_EN  Defined: first-word-fall-through. An output register holds
//                 the head word. It is loaded automatically, and rd_en
//                 acknowledges it.
//                 Undefined (default): standard mode. A read returns the word
//                 on dout one cycle after rd_en.
//
// Ports:
//   clk         rising-edge clock
//   srst        synchronous active-high reset
//   din/wr_en   write data / write request (ignored while full)
//   full        data_count == DEPTH
//   prog_full   data_count >= PROG_FULL_THRESH
//   rd_en       read request (FWFT: acknowledge of dout)
//   dout        read data, holds its value when no new word is read
//   valid       dout carries a freshly read word (FWFT: output stage occupied)
//   empty       no word readable
//   prog_empty  data_count <= PROG_EMPTY_THRESH
//   data_count  occupancy, 0..DEPTH
//   overflow    one-cycle pulse after a rejected write
//   underflow   one-cycle pulse after a rejected read
// ----------------------------------------------------------------------------
module sync_fifo_prog #(
  parameter int WIDTH             = 85,
  parameter int DEPTH             = 8,
  parameter int PROG_FULL_THRESH  = 3,
  parameter int PROG_EMPTY_THRESH = 1,
  localparam int CW               = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic             prog_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             empty,
  output logic             prog_empty,
  output logic [CW-1:0]    data_count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // The flags decode the registered count, so they describe the state left
  // by the previous edge.
  assign full       = (data_count == CW'(DEPTH));
  assign prog_full  = (data_count >= CW'(PROG_FULL_THRESH));
  assign prog_empty = (data_count <= CW'(PROG_EMPTY_THRESH));

  // A write is never accepted while full, even if a read happens in the
  // same cycle.
  assign wr_acc = wr_en & ~full;

  // NOTE: the storage array has no reset. Clearing it would block RAM
  // inference, and a word is never read before it has been written.
  always_ff @(posedge clk) begin
    if (!srst && wr_acc) begin
      ram[wr_ptr] <= din;
    end
  end

`ifdef FIFO_FWFT_EN

  // data_count covers the RAM entries plus the output register. ram_count is
  // the number of words still held in the RAM.
  logic [CW-1:0] ram_count;
  logic          load;

  assign empty     = ~valid;
  assign rd_acc    = rd_en & valid;
  assign ram_count = data_count - CW'(valid);
  // The head is refilled when the output register is idle or is being
  // consumed in this cycle, which gives back-to-back delivery.
  assign load      = (ram_count != '0) && (~valid || rd_acc);

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_ptr <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else if (load) begin
      dout   <= ram[rd_ptr];
      rd_ptr <= rd_ptr + 1'b1;
      valid  <= 1'b1;
    end else if (rd_acc) begin
      valid  <= 1'b0;
    end
  end

`else

  assign empty  = (data_count == '0);
  assign rd_acc = rd_en & ~empty;

  // valid marks only the cycle right after an accepted read. dout keeps its
  // last value at all other times.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_ptr <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= rd_acc;
      if (rd_acc) begin
        dout   <= ram[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`endif

  // The pointers are exactly log2(DEPTH) bits wide, so they wrap from
  // DEPTH-1 to 0 without extra logic.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr     <= '0;
      data_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // state from before the edge, whatever the statement order.
      overflow  <= wr_en & full;
      underflow <= rd_en & ~rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
    end
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO that buffers tokens between the parser and literal-copy stages of the decompressor.
- Replaces the fixed 8-entry parser/literal buffer with a generic block: configurable width and depth, programmable full/empty thresholds, occupancy count, and sticky-free overflow/underflow pulses.
- Optional first-word-fall-through read mode.
- Single clock domain; storage is inferred RAM or registers.

Parameters:
WIDTH, 85, data word width in bits (>=1)
DEPTH, 8, number of storage entries; power of two, >=2
PROG_FULL_THRESH, 3, prog_full asserts when data_count >= this value (1..DEPTH)
PROG_EMPTY_THRESH, 1, prog_empty asserts when data_count <= this value (0..DEPTH-1)
CW, $clog2(DEPTH)+1, derived count width (localparam)

Ports:
clk  in  1  clock, all logic on rising edge
srst  in  1  synchronous reset, active-high
din  in  WIDTH  write data
wr_en  in  1  write request
full  out  1  data_count == DEPTH
prog_full  out  1  data_count >= PROG_FULL_THRESH
rd_en  in  1  read request (FWFT: acknowledge of dout)
dout  out  WIDTH  read data
valid  out  1  dout holds a freshly read word (see Behaviour)
empty  out  1  no word readable
prog_empty  out  1  data_count <= PROG_EMPTY_THRESH
data_count  out  CW  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (srst=1 at clk edge):
  - Pointers 0, data_count 0, dout 0, valid 0, empty 1, full 0, prog_full 0, prog_empty 1, overflow 0, underflow 0.
  - RAM contents are not cleared.
  - A reset asserted mid-operation discards all stored words on that edge; wr_en and rd_en are ignored in that cycle.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. No modulo logic.
- Write accepted: wr_acc = wr_en & ~full. The word is stored at wr_ptr and wr_ptr increments.
- Write rejected: wr_en & full -> no state change; overflow=1 on the next cycle for exactly one cycle.
- Read accepted: rd_acc = rd_en & ~empty. In standard mode, dout <= ram[rd_ptr] and rd_ptr increments.
- Read rejected: rd_en & empty -> dout holds its value; underflow=1 on the next cycle for one cycle.
- data_count update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both are accepted or neither is.
- Simultaneous rd_en & wr_en:
  - When empty: only the write is accepted. underflow pulses; data_count 0->1.
  - When full: only the read is accepted. overflow pulses; data_count DEPTH->DEPTH-1.
  - Write-when-full is never accepted, even with a concurrent read.
- Standard-mode timing:
  - Read latency is 1 cycle: valid=1 in the cycle after rd_acc, else 0.
  - dout holds its last value while valid=0.
- Flags:
  - full, empty, prog_full and prog_empty are combinational decodes of the registered data_count, so they reflect state after the previous edge.
  - A word written at edge N is readable (empty=0) from cycle N+1.
- Read-during-write to the same address cannot occur: a read requires a stored word.

Optional Feature:
FIFO_FWFT_EN
- Defined:
  - First-word-fall-through mode. An output register stage holds the head word.
  - When the output stage is empty and the RAM is non-empty, the head is loaded automatically. dout and valid=1 appear one cycle after the word becomes available; there is no rd_en required.
  - valid = output stage occupied, and empty = ~valid.
  - rd_en consumes dout. If another word is available, it is presented on the next cycle back-to-back; otherwise valid drops.
  - data_count counts RAM entries plus the output stage. full still means data_count == DEPTH: storage is DEPTH-1 RAM entries plus 1 output register.
  - rd_en while valid=0 gives an underflow pulse.
- Undefined: standard mode as above.

Test Plan:
- Reset, then write 8 words 0x1..0x8 with DEPTH=8 -> data_count counts 1..8; prog_full=1 from count 3; full=1 after the 8th write; a 9th wr_en gives overflow=1 for one cycle and data_count stays 8.
- From full, read 8 times -> dout sequence 0x1..0x8, each with valid=1 one cycle after rd_en; empty=1 after the last read; a further rd_en gives underflow=1 and dout stays 0x8.
- Fill with 6 words, then hold wr_en=rd_en=1 for 20 cycles with incrementing data -> data_count stays 6; output order matches input order across 2+ pointer wraps.
- Empty FIFO, wr_en=rd_en=1 with din=0xA5 -> write accepted, underflow pulse, data_count=1, valid=0; the next read returns 0xA5.
- 5 words stored, srst pulsed for one cycle with wr_en=1 -> data_count=0, empty=1, valid=0, dout=0; the next write/read returns the newly written word only.
- FIFO_FWFT_EN defined: write 0x11 into an empty FIFO -> after latency, valid=1 and dout=0x11 with rd_en=0; rd_en=1 with 0x22 queued -> dout=0x22 on the next cycle, valid stays 1.
